// File: rtl/qlearn_step_ctrl_if.sv
// Policy handshake and Q-table strobe bundle
// for the Q-learning step controller.
interface qlearn_step_ctrl_if #(
    parameter int STATE_W  = 6,
    parameter int ACTION_W = 4
);
    logic                act_req;
    logic                act_vld;
    logic [ACTION_W-1:0] act;
    logic [STATE_W-1:0]  nxt_state;
    logic                q_rd_en;
    logic [STATE_W-1:0]  q_rd_state;
    logic [ACTION_W-1:0] q_rd_action;
    logic                q_wr_en;
    logic [STATE_W-1:0]  q_wr_state;
    logic [ACTION_W-1:0] q_wr_action;

    modport master (
        output act_req,
        input  act_vld,
        input  act,
        input  nxt_state,
        output q_rd_en,
        output q_rd_state,
        output q_rd_action,
        output q_wr_en,
        output q_wr_state,
        output q_wr_action
    );

    modport slave (
        input  act_req,
        output act_vld,
        output act,
        output nxt_state,
        input  q_rd_en,
        input  q_rd_state,
        input  q_rd_action,
        input  q_wr_en,
        input  q_wr_state,
        input  q_wr_action
    );
endinterface

// File: rtl/qlearn_step_ctrl.sv
// Sequences one Q-learning episode: select, read,
// wait datapath latency, write, advance, stop.
module qlearn_step_ctrl #(
    parameter int STATE_W    = 6,
    parameter int ACTION_W   = 4,
    parameter int STEP_W     = 8,
    parameter int PIPE_LAT   = 2,
    parameter int MAX_STEPS  = 255,
    parameter int GOAL_STATE = 63
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [STATE_W-1:0] init_state,
    qlearn_step_ctrl_if.master bus,
    output logic               busy,
    output logic [STEP_W-1:0]  step_cnt,
    output logic               episode_done,
    output logic               aborted
);

    localparam int CNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [STATE_W-1:0] GOAL = STATE_W'(GOAL_STATE);
    localparam logic [STEP_W-1:0]  MAXS = STEP_W'(MAX_STEPS);
    localparam logic [CNT_W-1:0]   LAT  = CNT_W'(PIPE_LAT - 1);

    typedef enum logic [2:0] {
        IDLE, SELECT, READ, WAIT, WRITE, ADVANCE, DONE
    } state_e;

    state_e              state_q, state_d;
    logic [STATE_W-1:0]  cur_q, cur_d;
    logic [ACTION_W-1:0] act_q, act_d;
    logic [STATE_W-1:0]  nxt_q, nxt_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [STEP_W-1:0]   step_inc;

    logic                act_req_q, act_req_d;
    logic                rd_en_q, rd_en_d;
    logic [STATE_W-1:0]  rd_state_q, rd_state_d;
    logic [ACTION_W-1:0] rd_action_q, rd_action_d;
    logic                wr_en_q, wr_en_d;
    logic [STATE_W-1:0]  wr_state_q, wr_state_d;
    logic [ACTION_W-1:0] wr_action_q, wr_action_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                aborted_q, aborted_d;

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        act_d    = act_q;
        nxt_d    = nxt_q;
        cnt_d    = cnt_q;
        step_d   = step_q;
        step_inc = step_q + 1'b1;
        // abort overrides every transition outside IDLE
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        cur_d   = init_state;
                        step_d  = '0;
                        state_d = (init_state == GOAL) ? DONE : SELECT;
                    end
                end
                SELECT: begin
                    if (bus.act_vld) begin
                        act_d   = bus.act;
                        nxt_d   = bus.nxt_state;
                        state_d = READ;
                    end
                end
                READ: begin
                    cnt_d   = LAT;
                    state_d = WAIT;
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_d = WRITE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                WRITE: state_d = ADVANCE;
                ADVANCE: begin
                    cur_d  = nxt_q;
                    step_d = step_inc;
                    if (nxt_q == GOAL || step_inc == MAXS) begin
                        state_d = DONE;
                    end else begin
                        state_d = SELECT;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        act_req_d   = (state_d == SELECT);
        rd_en_d     = (state_d == READ);
        rd_state_d  = rd_en_d ? cur_d : '0;
        rd_action_d = rd_en_d ? act_d : '0;
        wr_en_d     = (state_d == WRITE);
        wr_state_d  = wr_en_d ? cur_d : '0;
        wr_action_d = wr_en_d ? act_d : '0;
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        aborted_d   = abort && (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            act_q       <= '0;
            nxt_q       <= '0;
            cnt_q       <= '0;
            step_q      <= '0;
            act_req_q   <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_state_q  <= '0;
            rd_action_q <= '0;
            wr_en_q     <= 1'b0;
            wr_state_q  <= '0;
            wr_action_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            act_q       <= act_d;
            nxt_q       <= nxt_d;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            act_req_q   <= act_req_d;
            rd_en_q     <= rd_en_d;
            rd_state_q  <= rd_state_d;
            rd_action_q <= rd_action_d;
            wr_en_q     <= wr_en_d;
            wr_state_q  <= wr_state_d;
            wr_action_q <= wr_action_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    assign bus.act_req     = act_req_q;
    assign bus.q_rd_en     = rd_en_q;
    assign bus.q_rd_state  = rd_state_q;
    assign bus.q_rd_action = rd_action_q;
    assign bus.q_wr_en     = wr_en_q;
    assign bus.q_wr_state  = wr_state_q;
    assign bus.q_wr_action = wr_action_q;
    assign busy            = busy_q;
    assign step_cnt        = step_q;
    assign episode_done    = done_q;
    assign aborted         = aborted_q;

endmodule

// File: tb/tb_qlearn_step_ctrl.sv
// Bench for qlearn_step_ctrl: two instances driven in
// parallel, checked against a schedule-based model.
module tb_qlearn_step_ctrl;

    localparam int GOAL = 63;
    localparam int LAT0 = 2;
    localparam int LAT1 = 1;
    localparam int MAX0 = 255;
    localparam int MAX1 = 4;

    logic       clk;
    logic       rst_n;
    logic       s_start;
    logic       s_abort;
    logic [5:0] s_init;
    logic       s_vld;
    logic [3:0] s_act;
    logic [5:0] s_nxt;

    qlearn_step_ctrl_if if0();
    qlearn_step_ctrl_if if1();

    assign if0.act_vld   = s_vld;
    assign if0.act       = s_act;
    assign if0.nxt_state = s_nxt;
    assign if1.act_vld   = s_vld;
    assign if1.act       = s_act;
    assign if1.nxt_state = s_nxt;

    logic       o_busy[2];
    logic [7:0] o_step[2];
    logic       o_done[2];
    logic       o_abt[2];
    logic       o_req[2];
    logic       o_rd[2];
    logic [5:0] o_rs[2];
    logic [3:0] o_ra[2];
    logic       o_wr[2];
    logic [5:0] o_ws[2];
    logic [3:0] o_wa[2];

    qlearn_step_ctrl #(
        .PIPE_LAT(LAT0), .MAX_STEPS(MAX0), .GOAL_STATE(GOAL)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .start(s_start),
        .abort(s_abort), .init_state(s_init), .bus(if0.master),
        .busy(o_busy[0]), .step_cnt(o_step[0]),
        .episode_done(o_done[0]), .aborted(o_abt[0])
    );

    qlearn_step_ctrl #(
        .PIPE_LAT(LAT1), .MAX_STEPS(MAX1), .GOAL_STATE(GOAL)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .start(s_start),
        .abort(s_abort), .init_state(s_init), .bus(if1.master),
        .busy(o_busy[1]), .step_cnt(o_step[1]),
        .episode_done(o_done[1]), .aborted(o_abt[1])
    );

    assign o_req[0] = if0.act_req;
    assign o_rd[0]  = if0.q_rd_en;
    assign o_rs[0]  = if0.q_rd_state;
    assign o_ra[0]  = if0.q_rd_action;
    assign o_wr[0]  = if0.q_wr_en;
    assign o_ws[0]  = if0.q_wr_state;
    assign o_wa[0]  = if0.q_wr_action;
    assign o_req[1] = if1.act_req;
    assign o_rd[1]  = if1.q_rd_en;
    assign o_rs[1]  = if1.q_rd_state;
    assign o_ra[1]  = if1.q_rd_action;
    assign o_wr[1]  = if1.q_wr_en;
    assign o_ws[1]  = if1.q_wr_state;
    assign o_wa[1]  = if1.q_wr_action;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // model: expected event times per instance
    bit m_busy[2], m_req[2], m_abt[2];
    int m_cur[2], m_act[2], m_nxt[2], m_steps[2];
    int rd_at[2], wr_at[2], adv_at[2], done_at[2];

    // observed activity, used for literal checks
    int rd_cnt[2], wr_cnt[2], done_cnt[2], abt_cnt[2], req_cnt[2];
    int last_rd[2], last_dly[2], last_rs[2], last_ra[2];

    function automatic int lat(input int i);
        return (i == 0) ? LAT0 : LAT1;
    endfunction

    function automatic int maxs(input int i);
        return (i == 0) ? MAX0 : MAX1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, got, exp, cyc);
        end
    endtask

    task automatic model_reset(input int i);
        m_busy[i]  = 0;
        m_req[i]   = 0;
        m_abt[i]   = 0;
        m_cur[i]   = 0;
        m_act[i]   = 0;
        m_nxt[i]   = 0;
        m_steps[i] = 0;
        rd_at[i]   = -100;
        wr_at[i]   = -100;
        adv_at[i]  = -100;
        done_at[i] = -100;
    endtask

    task automatic model_step(input int i, input int k);
        m_abt[i] = 0;
        if (!m_busy[i]) begin
            if (s_start) begin
                m_cur[i]   = s_init;
                m_steps[i] = 0;
                m_busy[i]  = 1;
                if (s_init == GOAL) done_at[i] = k;
                else m_req[i] = 1;
            end
        end else if (s_abort) begin
            m_busy[i]  = 0;
            m_req[i]   = 0;
            m_abt[i]   = 1;
            rd_at[i]   = -100;
            wr_at[i]   = -100;
            adv_at[i]  = -100;
            done_at[i] = -100;
        end else begin
            if (done_at[i] == k - 1) m_busy[i] = 0;
            if (m_req[i] && s_vld) begin
                m_req[i]  = 0;
                m_act[i]  = s_act;
                m_nxt[i]  = s_nxt;
                rd_at[i]  = k;
                wr_at[i]  = k + lat(i) + 1;
                adv_at[i] = k + lat(i) + 3;
            end
            if (adv_at[i] == k) begin
                m_cur[i] = m_nxt[i];
                m_steps[i]++;
                if (m_cur[i] == GOAL || m_steps[i] == maxs(i))
                    done_at[i] = k;
                else
                    m_req[i] = 1;
            end
        end
    endtask

    task automatic compare(input int i, input int k);
        bit r, w;
        r = (rd_at[i] == k);
        w = (wr_at[i] == k);
        chk($sformatf("d%0d_act_req", i), 32'(o_req[i]), 32'(m_req[i]));
        chk($sformatf("d%0d_rd_en", i), 32'(o_rd[i]), 32'(r));
        chk($sformatf("d%0d_rd_state", i), 32'(o_rs[i]),
            r ? m_cur[i] : 0);
        chk($sformatf("d%0d_rd_action", i), 32'(o_ra[i]),
            r ? m_act[i] : 0);
        chk($sformatf("d%0d_wr_en", i), 32'(o_wr[i]), 32'(w));
        chk($sformatf("d%0d_wr_state", i), 32'(o_ws[i]),
            w ? m_cur[i] : 0);
        chk($sformatf("d%0d_wr_action", i), 32'(o_wa[i]),
            w ? m_act[i] : 0);
        chk($sformatf("d%0d_busy", i), 32'(o_busy[i]), 32'(m_busy[i]));
        chk($sformatf("d%0d_step_cnt", i), 32'(o_step[i]), m_steps[i]);
        chk($sformatf("d%0d_done", i), 32'(o_done[i]),
            32'(done_at[i] == k));
        chk($sformatf("d%0d_aborted", i), 32'(o_abt[i]), 32'(m_abt[i]));
    endtask

    task automatic observe(input int i);
        if (o_req[i] === 1'b1) req_cnt[i]++;
        if (o_done[i] === 1'b1) done_cnt[i]++;
        if (o_abt[i] === 1'b1) abt_cnt[i]++;
        if (o_rd[i] === 1'b1) begin
            rd_cnt[i]++;
            last_rd[i] = cyc;
            last_rs[i] = o_rs[i];
            last_ra[i] = o_ra[i];
        end
        if (o_wr[i] === 1'b1) begin
            wr_cnt[i]++;
            last_dly[i] = cyc - last_rd[i];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) model_reset(i);
            else model_step(i, cyc);
            compare(i, cyc);
            observe(i);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            model_reset(i);
            chk($sformatf("d%0d_rst_busy", i), 32'(o_busy[i]), 0);
            chk($sformatf("d%0d_rst_req", i), 32'(o_req[i]), 0);
            chk($sformatf("d%0d_rst_rd", i), 32'(o_rd[i]), 0);
            chk($sformatf("d%0d_rst_wr", i), 32'(o_wr[i]), 0);
            chk($sformatf("d%0d_rst_step", i), 32'(o_step[i]), 0);
            chk($sformatf("d%0d_rst_flags", i),
                32'({o_done[i], o_abt[i], o_rs[i], o_ws[i]}), 0);
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic run_idle(input bit use0, input bit use1,
                            input int budget, input string nm);
        int n = 0;
        while (((use0 && o_busy[0]) || (use1 && o_busy[1]))
               && n < budget) begin
            tick();
            n++;
        end
        chk({nm, "_timeout"}, 32'(n < budget), 1);
    endtask

    task automatic wait_rd0(input int budget, input string nm);
        int n = 0;
        while (o_rd[0] !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk({nm, "_rd_timeout"}, 32'(n < budget), 1);
    endtask

    int sn_rd[2], sn_wr[2], sn_dn[2], sn_ab[2], sn_rq;

    task automatic snap();
        for (int i = 0; i < 2; i++) begin
            sn_rd[i] = rd_cnt[i];
            sn_wr[i] = wr_cnt[i];
            sn_dn[i] = done_cnt[i];
            sn_ab[i] = abt_cnt[i];
        end
        sn_rq = req_cnt[0];
    endtask

    initial begin
        rst_n   = 1'b0;
        s_start = 1'b0;
        s_abort = 1'b0;
        s_init  = '0;
        s_vld   = 1'b0;
        s_act   = '0;
        s_nxt   = '0;
        for (int i = 0; i < 2; i++) begin
            model_reset(i);
            rd_cnt[i] = 0; wr_cnt[i] = 0; done_cnt[i] = 0;
            abt_cnt[i] = 0; req_cnt[i] = 0; last_rd[i] = 0;
            last_dly[i] = 0; last_rs[i] = 0; last_ra[i] = 0;
        end
        #12;
        do_reset();

        // idle: act_vld toggling is ignored
        for (int n = 0; n < 4; n++) begin
            s_vld = n[0];
            tick();
        end

        // single step straight to goal
        snap();
        s_init = 6'd5; s_act = 4'd3; s_nxt = 6'd63; s_vld = 1'b1;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        run_idle(1, 1, 40, "goal1");
        chk("t2_rd_state", last_rs[0], 5);
        chk("t2_rd_action", last_ra[0], 3);
        chk("t2_wr_delay_lat2", last_dly[0], 3);
        chk("t2_wr_delay_lat1", last_dly[1], 2);
        chk("t2_step_cnt", 32'(o_step[0]), 1);
        chk("t2_done_pulses", done_cnt[0] - sn_dn[0], 1);
        chk("t2_rd_pairs", rd_cnt[0] - sn_rd[0], 1);

        // start already at goal
        snap();
        s_init = 6'd63; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        run_idle(1, 1, 10, "goal0");
        chk("t3_no_rd", rd_cnt[0] - sn_rd[0], 0);
        chk("t3_no_wr", wr_cnt[0] - sn_wr[0], 0);
        chk("t3_done", done_cnt[0] - sn_dn[0], 1);
        chk("t3_step_cnt", 32'(o_step[0]), 0);

        // never reach goal: instance 1 stops at 4 steps
        snap();
        s_init = 6'd1; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        for (int n = 0; n < 200 && o_busy[1]; n++) begin
            s_nxt = 6'($urandom_range(0, 62));
            s_act = 4'($urandom);
            tick();
        end
        chk("t4_ended", 32'(o_busy[1]), 0);
        chk("t4_rd_pairs", rd_cnt[1] - sn_rd[1], 4);
        chk("t4_wr_pairs", wr_cnt[1] - sn_wr[1], 4);
        chk("t4_step_cnt", 32'(o_step[1]), 4);
        chk("t4_done", done_cnt[1] - sn_dn[1], 1);
        s_abort = 1'b1;
        tick();
        s_abort = 1'b0;
        tick();
        chk("t4_idle_abort_ignored", abt_cnt[1] - sn_ab[1], 0);

        // abort while waiting on the datapath
        snap();
        s_init = 6'd2; s_nxt = 6'd10; s_vld = 1'b1; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        wait_rd0(20, "t5");
        tick();
        s_abort = 1'b1;
        tick();
        s_abort = 1'b0;
        for (int n = 0; n < 8; n++) tick();
        chk("t5_no_wr0", wr_cnt[0] - sn_wr[0], 0);
        chk("t5_no_wr1", wr_cnt[1] - sn_wr[1], 0);
        chk("t5_aborted", abt_cnt[0] - sn_ab[0], 1);
        chk("t5_no_done", done_cnt[0] - sn_dn[0], 0);
        chk("t5_step_cnt", 32'(o_step[0]), 0);

        // reset while waiting on the datapath
        snap();
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        wait_rd0(20, "t5r");
        tick();
        do_reset();
        for (int n = 0; n < 6; n++) tick();
        chk("t5r_no_wr", wr_cnt[0] - sn_wr[0], 0);

        // slow policy with start pulses while busy
        snap();
        s_vld = 1'b0; s_init = 6'd7; s_start = 1'b1;
        tick();
        for (int n = 0; n < 9; n++) begin
            s_start = 1'($urandom_range(0, 1));
            s_init  = 6'($urandom);
            tick();
        end
        s_start = 1'b0; s_vld = 1'b1; s_act = 4'd9; s_nxt = 6'd63;
        tick();
        run_idle(1, 1, 40, "t6");
        chk("t6_req_cycles", req_cnt[0] - sn_rq, 10);
        chk("t6_rd_state", last_rs[0], 7);
        chk("t6_wr_delay_lat1", last_dly[1], 2);
        chk("t6_step_cnt", 32'(o_step[1]), 1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            s_start = ($urandom_range(0, 3) == 0);
            s_init  = ($urandom_range(0, 15) == 0) ?
                      6'd63 : 6'($urandom);
            s_abort = ($urandom_range(0, 49) == 0);
            s_vld   = 1'($urandom);
            s_act   = 4'($urandom);
            s_nxt   = ($urandom_range(0, 7) == 0) ?
                      6'd63 : 6'($urandom);
            if ($urandom_range(0, 699) == 0) do_reset();
            else tick();
        end
        s_start = 1'b0;
        s_abort = 1'b1;
        tick();
        s_abort = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
